// File: rtl/modulation_segment_tx.sv
// Transmit-side segment modulator: expands each accepted bit into SEGMENTS
// alternating +/-AMP Q16.16 samples. Define MODULATION_QUEUE_EN for a one-entry pending buffer.
`timescale 1ns/1ps

module modulation_segment_tx #(
  parameter int unsigned SEGMENTS = 10,
  parameter logic [31:0] AMP      = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] input_bit,
  input  logic        start,
  output logic [31:0] sample,
  output logic [3:0]  sample_idx,
  output logic        valid,
  output logic        last,
  output logic        busy,
  output logic        drop
);

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  localparam logic [3:0]  LAST_IDX = 4'(SEGMENTS - 1);
  localparam logic [31:0] AMP_NEG  = ~AMP + 32'd1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_cur_bit;
  logic        w_cur_bit_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic        r_valid;
  logic        r_last;
  logic        r_drop;
  logic [31:0] r_sample;
  logic        w_drop_nxt;
  logic        w_in_bit;
  logic        w_emit_nxt;
  logic        w_pos_nxt;
`ifdef MODULATION_QUEUE_EN
  logic        r_pend_vld;
  logic        w_pend_vld_nxt;
  logic        r_pend_bit;
  logic        w_pend_bit_nxt;
`endif

  assign w_in_bit = |input_bit;

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_bit_nxt = r_cur_bit;
    w_idx_nxt     = r_idx;
    w_drop_nxt    = 1'b0;
`ifdef MODULATION_QUEUE_EN
    w_pend_vld_nxt = r_pend_vld;
    w_pend_bit_nxt = r_pend_bit;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_EMIT;
          w_cur_bit_nxt = w_in_bit;
          w_idx_nxt     = '0;
        end
      end
      ST_EMIT: begin
        if (r_last) begin
          w_idx_nxt = '0;
`ifdef MODULATION_QUEUE_EN
          // Pending bit goes first; a start in the same cycle refills the buffer.
          if (r_pend_vld) begin
            w_cur_bit_nxt  = r_pend_bit;
            w_pend_vld_nxt = start;
            if (start) w_pend_bit_nxt = w_in_bit;
          end else
`endif
          if (start) w_cur_bit_nxt = w_in_bit;
          else       w_state_nxt   = ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + 4'd1;
`ifdef MODULATION_QUEUE_EN
          if (start) begin
            if (!r_pend_vld) begin
              w_pend_vld_nxt = 1'b1;
              w_pend_bit_nxt = w_in_bit;
            end else begin
              w_drop_nxt = 1'b1;
            end
          end
`else
          w_drop_nxt = start;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with r_idx.
  assign w_emit_nxt = (w_state_nxt == ST_EMIT);
  assign w_pos_nxt  = w_idx_nxt[0] ^ w_cur_bit_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cur_bit <= 1'b0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_drop    <= 1'b0;
      r_sample  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_bit <= w_cur_bit_nxt;
      r_idx     <= w_idx_nxt;
      r_valid   <= w_emit_nxt;
      r_last    <= w_emit_nxt && (w_idx_nxt == LAST_IDX);
      r_drop    <= w_drop_nxt;
      r_sample  <= w_emit_nxt ? (w_pos_nxt ? AMP : AMP_NEG) : '0;
    end
  end

`ifdef MODULATION_QUEUE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_vld <= 1'b0;
      r_pend_bit <= 1'b0;
    end else begin
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_bit <= w_pend_bit_nxt;
    end
  end
`endif

  assign sample     = r_sample;
  assign sample_idx = r_idx;
  assign valid      = r_valid;
  assign busy       = r_valid;
  assign last       = r_last;
  assign drop       = r_drop;

endmodule

// File: tb/tb_modulation_segment_tx.sv
// Directed bench for modulation_segment_tx (default 10-segment instance plus a
// 4-segment / half-amplitude instance); expectations follow MODULATION_QUEUE_EN.
`timescale 1ns/1ps

module tb_modulation_segment_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] input_bit = '0;
  logic        start = 1'b0;
  logic [31:0] sample;
  logic [3:0]  sample_idx;
  logic        valid, last, busy, drop;

  logic [31:0] input_bit4 = '0;
  logic        start4 = 1'b0;
  logic [31:0] sample4;
  logic [3:0]  sample_idx4;
  logic        valid4, last4, busy4, drop4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  modulation_segment_tx u_dut (
    .clk(clk), .reset(reset), .input_bit(input_bit), .start(start),
    .sample(sample), .sample_idx(sample_idx), .valid(valid), .last(last),
    .busy(busy), .drop(drop)
  );

  modulation_segment_tx #(.SEGMENTS(4), .AMP(32'h0000_8000)) u_dut4 (
    .clk(clk), .reset(reset), .input_bit(input_bit4), .start(start4),
    .sample(sample4), .sample_idx(sample_idx4), .valid(valid4), .last(last4),
    .busy(busy4), .drop(drop4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start(input logic [31:0] val);
    input_bit = val;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    input_bit = 32'h5A5A_0000;
  endtask

  task automatic check_sample(input logic b, input int i, input logic exp_drop);
    logic [31:0] exp_s;
    exp_s = (((i % 2) == 0) == b) ? 32'h0001_0000 : 32'hFFFF_0000;
    check("valid", {31'd0, valid}, 32'd1);
    check("busy", {31'd0, busy}, 32'd1);
    check("idx", {28'd0, sample_idx}, 32'(i));
    check("last", {31'd0, last}, (i == 9) ? 32'd1 : 32'd0);
    check("sample", sample, exp_s);
    check("drop", {31'd0, drop}, {31'd0, exp_drop});
  endtask

  // smask: cycles (by index) carrying a start; vmask: bit value of that start;
  // dmask: cycles where a drop pulse is expected.
  task automatic frame(input logic b, input logic [15:0] smask, input logic [15:0] vmask,
                       input logic [15:0] dmask);
    for (int i = 0; i < 10; i++) begin
      check_sample(b, i, dmask[i]);
      if (smask[i]) begin
        start     = 1'b1;
        input_bit = vmask[i] ? 32'h0000_0100 : 32'h0;
      end
      tick();
      start     = 1'b0;
      input_bit = 32'h5A5A_0000;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_last"}, {31'd0, last}, 32'd0);
    check({tag, "_drop"}, {31'd0, drop}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sample"}, sample, 32'd0);
    check({tag, "_idx"}, {28'd0, sample_idx}, 32'd0);
    check_idle(tag);
  endtask

  initial begin
    logic [31:0] sweep_exp [4];
    sweep_exp[0] = 32'h0000_8000;
    sweep_exp[1] = 32'hFFFF_8000;
    sweep_exp[2] = 32'h0000_8000;
    sweep_exp[3] = 32'hFFFF_8000;

    #1;
    check_reset_outputs("rst");
    tick();
    reset = 1'b1;
    tick();
    check_idle("post_rst");

    // Basic bit 1, bit 0 and MSB-only word treated as 1.
    send_start(32'h0000_0001);
    frame(1'b1, 16'h0, 16'h0, 16'h0);
    check_idle("end_b1");
    send_start(32'h0000_0000);
    frame(1'b0, 16'h0, 16'h0, 16'h0);
    check_idle("end_b0");
    send_start(32'h8000_0000);
    frame(1'b1, 16'h0, 16'h0, 16'h0);
    check_idle("end_msb");

    // Back-to-back: start bit 0 in the last cycle.
    send_start(32'h1);
    frame(1'b1, 16'h0200, 16'h0000, 16'h0);
    frame(1'b0, 16'h0, 16'h0, 16'h0);
    check_idle("end_b2b");

`ifdef MODULATION_QUEUE_EN
    send_start(32'h1);
    frame(1'b1, 16'h0028, 16'h0020, 16'h0040);
    frame(1'b0, 16'h0, 16'h0, 16'h0);
    check_idle("end_queue");
    send_start(32'h1);
    frame(1'b1, 16'h0204, 16'h0200, 16'h0);
    frame(1'b0, 16'h0, 16'h0, 16'h0);
    frame(1'b1, 16'h0, 16'h0, 16'h0);
    check_idle("end_swap");
`else
    send_start(32'h1);
    frame(1'b1, 16'h0008, 16'h0000, 16'h0010);
    check_idle("end_nq_drop");
    send_start(32'h1);
    frame(1'b1, 16'h0204, 16'h0200, 16'h0008);
    frame(1'b1, 16'h0, 16'h0, 16'h0);
    check_idle("end_nq_last");
`endif

    // Reset at idx 4 with a start issued at idx 1.
    send_start(32'h1);
    for (int i = 0; i < 5; i++) begin
`ifdef MODULATION_QUEUE_EN
      check_sample(1'b1, i, 1'b0);
`else
      check_sample(1'b1, i, i == 2);
`endif
      if (i == 1) begin
        start     = 1'b1;
        input_bit = 32'h0;
      end
      if (i < 4) begin
        tick();
        start     = 1'b0;
        input_bit = 32'h5A5A_0000;
      end
    end
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rst_quiet_valid", {31'd0, valid}, 32'd0);
    end
    send_start(32'h0);
    frame(1'b0, 16'h0, 16'h0, 16'h0);
    check_idle("end_after_rst");

    // Parameter sweep instance.
    input_bit4 = 32'h1;
    start4     = 1'b1;
    tick();
    start4     = 1'b0;
    input_bit4 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check("sw_valid", {31'd0, valid4}, 32'd1);
      check("sw_idx", {28'd0, sample_idx4}, 32'(i));
      check("sw_last", {31'd0, last4}, (i == 3) ? 32'd1 : 32'd0);
      check("sw_sample", sample4, sweep_exp[i]);
      tick();
    end
    check("sw_end_valid", {31'd0, valid4}, 32'd0);
    check("sw_end_busy", {31'd0, busy4}, 32'd0);
    check("sw_drop", {31'd0, drop4}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
